// File: rtl/frame_sequencer.sv
// frame_sequencer: double-buffered frame scheduler (clear back buffer, render, swap on vblank)
module frame_sequencer #(
    parameter int          WIDTH       = 320,
    parameter int          HEIGHT      = 240,
    parameter int          ADDR_WIDTH  = 17,
    parameter logic [11:0] CLEAR_COLOR = 12'h000,
    parameter logic [15:0] DEPTH_CLEAR = 16'hFFFF
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  enable_in,
    input  logic                  vblank_in,
    input  logic                  render_done_in,
    input  logic                  frag_valid_in,
    input  logic [ADDR_WIDTH-1:0] frag_addr_in,
    input  logic [11:0]           frag_rgb_in,
    input  logic [15:0]           frag_depth_in,
    output logic                  frag_ready_out,
    output logic                  render_start_out,
    output logic                  fb_we_out,
    output logic [ADDR_WIDTH-1:0] fb_addr_out,
    output logic [11:0]           fb_rgb_out,
    output logic [15:0]           fb_depth_out,
    output logic                  fb_depth_test_out,
    output logic                  back_buffer_out,
    output logic [15:0]           frame_count_out,
    output logic [7:0]            missed_vblank_out,
    output logic                  busy_out
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WIDTH * HEIGHT - 1);
    typedef enum logic [2:0] {IDLE, CLEAR, START, RENDER, WAIT_VBLANK, SWAP} state_t;
    state_t state;
    logic   go_clear;
    // A new frame begins from IDLE or straight out of SWAP while enabled
    assign go_clear = enable_in && (state == IDLE || state == SWAP);
    // Frame FSM; the write address register doubles as the clear counter
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state             <= IDLE;
            frag_ready_out    <= 1'b0;
            render_start_out  <= 1'b0;
            fb_we_out         <= 1'b0;
            fb_addr_out       <= '0;
            fb_rgb_out        <= '0;
            fb_depth_out      <= '0;
            fb_depth_test_out <= 1'b0;
            back_buffer_out   <= 1'b1;
            frame_count_out   <= '0;
            missed_vblank_out <= '0;
            busy_out          <= 1'b0;
        end else begin
            fb_we_out        <= 1'b0;
            render_start_out <= 1'b0;
            if (vblank_in && (state == CLEAR || state == START || state == RENDER) && missed_vblank_out != 8'hFF)
                missed_vblank_out <= missed_vblank_out + 8'd1;
            case (state)
                CLEAR: begin
                    if (fb_addr_out == LAST) begin
                        state            <= START;
                        render_start_out <= 1'b1;
                    end else begin
                        fb_we_out   <= 1'b1;
                        fb_addr_out <= fb_addr_out + ADDR_WIDTH'(1);
                    end
                end
                START: begin
                    state          <= RENDER;
                    frag_ready_out <= 1'b1;
                end
                RENDER: begin
                    if (frag_valid_in && frag_ready_out) begin
                        fb_we_out         <= 1'b1;
                        fb_addr_out       <= frag_addr_in;
                        fb_rgb_out        <= frag_rgb_in;
                        fb_depth_out      <= frag_depth_in;
                        fb_depth_test_out <= 1'b1;
                    end
                    if (render_done_in) begin
                        state          <= WAIT_VBLANK;
                        frag_ready_out <= 1'b0;
                    end
                end
                WAIT_VBLANK: begin
                    if (vblank_in) begin
                        state           <= SWAP;
                        back_buffer_out <= ~back_buffer_out;
                        frame_count_out <= frame_count_out + 16'd1;
                    end
                end
                SWAP: begin
                    if (!enable_in) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (go_clear) begin
                state             <= CLEAR;
                busy_out          <= 1'b1;
                fb_we_out         <= 1'b1;
                fb_addr_out       <= '0;
                fb_rgb_out        <= CLEAR_COLOR;
                fb_depth_out      <= DEPTH_CLEAR;
                fb_depth_test_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: random and directed stimulus against a frame-level reference model
module tb_frame_sequencer;
    localparam int N = 8;
    logic        clk = 0, rst = 0, enable = 0, vblank = 0, done = 0, fv = 0;
    logic [2:0]  fa = 0;
    logic [11:0] frgb = 0;
    logic [15:0] fd = 0;
    logic        ready, start, we, dtest, back, busy;
    logic [2:0]  addr;
    logic [11:0] rgb;
    logic [15:0] depth, frames;
    logic [7:0]  missed;
    int n_checks = 0, n_pass = 0, n_we = 0, n_start = 0;
    int ph = 0, clr_left = 0, e_missed = 0;
    bit e_we = 0, e_start = 0, e_ready = 0, e_busy = 0, e_dt = 0, e_back = 1;
    logic [2:0]  e_addr = 0;
    logic [11:0] e_rgb = 0;
    logic [15:0] e_depth = 0, e_frames = 0;

    frame_sequencer #(.WIDTH(4), .HEIGHT(2), .ADDR_WIDTH(3), .CLEAR_COLOR(12'h000), .DEPTH_CLEAR(16'hFFFF)) dut (
        .clk_in(clk), .rst_in(rst), .enable_in(enable), .vblank_in(vblank), .render_done_in(done),
        .frag_valid_in(fv), .frag_addr_in(fa), .frag_rgb_in(frgb), .frag_depth_in(fd),
        .frag_ready_out(ready), .render_start_out(start), .fb_we_out(we), .fb_addr_out(addr),
        .fb_rgb_out(rgb), .fb_depth_out(depth), .fb_depth_test_out(dtest), .back_buffer_out(back),
        .frame_count_out(frames), .missed_vblank_out(missed), .busy_out(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // phases: 0 idle, 1 clear, 2 start pulse, 3 render, 4 wait vblank, 5 swap
    task automatic model_edge();
        bit go;
        go = 0;
        e_we = 0;
        e_start = 0;
        if (!rst) begin
            ph = 0; e_back = 1; e_frames = 0; e_missed = 0;
        end else begin
            if (vblank && ph >= 1 && ph <= 3 && e_missed < 255) e_missed++;
            case (ph)
                0: go = enable;
                1: if (clr_left == 0) begin ph = 2; e_start = 1; end
                   else begin e_we = 1; e_addr = 3'(N - clr_left); clr_left--; end
                2: ph = 3;
                3: begin
                    if (fv) begin e_we = 1; e_addr = fa; e_rgb = frgb; e_depth = fd; e_dt = 1; end
                    if (done) ph = 4;
                end
                4: if (vblank) begin ph = 5; e_back = ~e_back; e_frames++; end
                default: begin go = enable; if (!enable) ph = 0; end
            endcase
            if (go) begin
                ph = 1; e_we = 1; e_addr = 0; e_rgb = 12'h000; e_depth = 16'hFFFF; e_dt = 0; clr_left = N - 1;
            end
        end
        e_ready = (ph == 3);
        e_busy = (ph != 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("ready", 32'(ready), 32'(e_ready));
        check("start", 32'(start), 32'(e_start));
        check("we", 32'(we), 32'(e_we));
        check("busy", 32'(busy), 32'(e_busy));
        check("back", 32'(back), 32'(e_back));
        check("frames", 32'(frames), 32'(e_frames));
        check("missed", 32'(missed), 32'(e_missed));
        if (e_we) begin
            check("addr", 32'(addr), 32'(e_addr));
            check("rgb", 32'(rgb), 32'(e_rgb));
            check("depth", 32'(depth), 32'(e_depth));
            check("dtest", 32'(dtest), 32'(e_dt));
        end
        if (we) n_we++;
        if (start) n_start++;
    endtask

    task automatic rand_frag();
        fv = 1'($urandom_range(0, 1));
        fa = 3'($urandom);
        frgb = 12'($urandom);
        fd = 16'($urandom);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40 && !ready; i++) begin rand_frag(); step(); end
        fv = 0;
        check("wait_ready", 32'(ready), 1);
    endtask

    task automatic pulse(input bit v, input bit d);
        vblank = v; done = d;
        step();
        vblank = 0; done = 0;
    endtask

    initial begin
        step();
        step();
        rst = 1; enable = 1; n_we = 0; n_start = 0;
        wait_ready();
        check("clear_writes", n_we, N);
        check("start_pulses", n_start, 1);
        fv = 1; fa = 3'd5; frgb = 12'hF00; fd = 16'h1234;
        step();
        fv = 0;
        check("frag_addr", 32'(addr), 5);
        check("frag_rgb", 32'(rgb), 32'h0F00);
        check("frag_dtest", 32'(dtest), 1);
        repeat (10) begin rand_frag(); step(); end
        fv = 0;
        pulse(1, 0); step(); pulse(1, 0);
        check("missed_two", 32'(missed), 2);
        fv = 1; fa = 3'd2;
        pulse(1, 1);
        fv = 0;
        check("done_frag_we", 32'(we), 1);
        check("missed_three", 32'(missed), 3);
        repeat (20) step();
        check("no_swap_yet", 32'(back), 1);
        pulse(1, 0);
        check("swap_back", 32'(back), 0);
        check("swap_frames", 32'(frames), 1);
        step();
        check("reclear_addr", 32'(addr), 0);
        wait_ready();
        repeat (6) begin rand_frag(); step(); end
        fv = 0;
        pulse(0, 1);
        repeat (5) step();
        pulse(1, 0);
        check("swap2_back", 32'(back), 1);
        check("swap2_frames", 32'(frames), 2);
        wait_ready();
        repeat (300) begin pulse(1, 0); step(); end
        check("missed_sat", 32'(missed), 255);
        enable = 0;
        pulse(0, 1);
        step();
        pulse(1, 0);
        step();
        n_we = 0; n_start = 0;
        repeat (20) pulse(1'($urandom_range(0, 1)), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_writes", n_we, 0);
        check("idle_starts", n_start, 0);
        enable = 1;
        for (int i = 0; i < 20 && !(we && addr == 3); i++) step();
        check("hit_addr3", 32'(addr), 3);
        rst = 0;
        step();
        check("rst_we", 32'(we), 0);
        check("rst_back", 32'(back), 1);
        check("rst_frames", 32'(frames), 0);
        rst = 1;
        step();
        check("restart_addr", 32'(addr), 0);
        check("restart_we", 32'(we), 1);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) != 0);
            enable = ($urandom_range(0, 7) != 0);
            vblank = ($urandom_range(0, 15) == 0);
            done = ($urandom_range(0, 19) == 0);
            rand_frag();
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
